wb_regfile_scoreboard: RTL
==========================

Name: wb_regfile_scoreboard

Overview:
- Consumer end of the MEM/WB pipeline register in the 5-stage MIPS pipeline.
- Selects the write-back value and writes the 32x32 register file.
- Serves the two ID-stage read ports with a same-cycle write bypass.
- Keeps a per-register pending-write scoreboard; ID uses it to stall on RAW hazards against in-flight producers.

Parameters:
- NREG, 32, number of architectural registers (index width fixed at 5).
- DW, 32, data width.
- CW, 2, width of each per-register pending counter (max 3 in flight: EX, MEM, WB).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_to_reg  in  2  from MEM/WB: 00 ALU, 01 memory, 10 PC+4 (jal), 11 reserved.
- reg_write  in  1  from MEM/WB: retiring instruction writes a register.
- read_data  in  DW  from MEM/WB: load data.
- alu_in  in  DW  from MEM/WB: ALU result.
- mux_reg_dst  in  5  from MEM/WB: destination register.
- addPC  in  DW  from MEM/WB: PC+4.
- wb_data  out  DW  selected write-back value (combinational).
- read_reg1, read_reg2  in  5  ID read addresses.
- use1, use2  in  1  ID instruction actually consumes port 1 / port 2.
- read_data1, read_data2  out  DW  ID read data (combinational).
- issue_valid  in  1  ID instruction with reg write advances to EX this cycle.
- issue_reg  in  5  its destination.
- kill_valid  in  1  in-flight writer squashed (branch/jump flush).
- kill_reg  in  5  its destination.
- stall  out  1  RAW hazard; hold PC and IF/ID, bubble ID/EX.
- sb_error  out  1  sticky scoreboard over/underflow flag.

Behaviour:
- Reset (rst=0, async):
  - All registers cleared to 0.
  - All pending counters cleared to 0.
  - sb_error=0.
  - Outputs follow combinationally from the cleared state.
- wb_data by mem_to_reg:
  - 00 -> alu_in.
  - 01 -> read_data.
  - 10 -> addPC.
  - 11 -> alu_in.
- Write: on posedge, if reg_write and mux_reg_dst!=0, then reg[mux_reg_dst] <= wb_data. Writes to $0 are ignored; $0 always reads 0.
- Read port k (combinational):
  - read_reg_k==0 -> 0.
  - Else if reg_write and mux_reg_dst==read_reg_k -> wb_data (bypass).
  - Else -> reg[read_reg_k].
- Counter update for register r!=0 at each posedge:
  - inc = issue_valid & issue_reg==r.
  - dec = (reg_write & mux_reg_dst==r) + (kill_valid & kill_reg==r); dec is 0..2.
  - pending[r] <= pending[r] + inc - dec.
  - Result <0: clamp to 0 and set sb_error.
  - Result >3: saturate at 3 and set sb_error.
  - Register 0 is never tracked; its count stays 0.
- Hazard for port k: eff_k = pending[read_reg_k] - (reg_write & mux_reg_dst==read_reg_k). hazard_k = read_reg_k!=0 & eff_k>0. A producer retiring this cycle is covered by the bypass, not a stall.
- stall = (use1 & hazard1) | (use2 & hazard2). Purely combinational, zero latency.
- ID must not assert issue_valid while stall=1. If it does, the issue is still counted.
- Simultaneous issue and retire of the same register: net 0 change.
- Simultaneous issue, retire and kill of the same register: net -1.
- sb_error clears only on reset.
- Reset mid-operation: all state is lost immediately. In-flight writes are not preserved, and pipeline registers are reset alongside.

Test Plan:
- Reset, then read $5 on both ports -> read_data1=read_data2=0; stall=0; sb_error=0.
- mem_to_reg=10, reg_write=1, mux_reg_dst=31, addPC=0x00400018 -> wb_data=0x00400018 and a same-cycle read of $31 returns it. After the edge, reg[31]=0x00400018.
- Issue write to $8, then read $8 with use1=1 in each of the next 2 cycles -> stall=1. In the cycle the MEM/WB inputs present reg_write=1, mux_reg_dst=8, alu_in=0xDEADBEEF -> stall=0 and read_data1=0xDEADBEEF. pending[8] returns to 0.
- Write to $0 with alu_in=0x1234 and issue_reg=0 -> reg[0] stays 0; stall never asserts on $0 reads.
- Issue $9 twice, then kill_reg=9 once, then retire $9 once -> pending[9] goes 1,2,1,0. Read of $9 stalls until the retire cycle.
- Retire $3 with pending[3]=0 -> sb_error=1 and stays 1 until rst=0. Issue $4 four times with no retire -> counter holds 3.

Source files
------------

// File: rtl/wb_regfile_scoreboard.sv
// MEM/WB consumer: write-back select, 32x32 register file with same-cycle bypass,
// and a per-register pending-write scoreboard driving the ID-stage RAW stall.
module wb_regfile_scoreboard #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int CW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mem_to_reg,
  input  logic          reg_write,
  input  logic [DW-1:0] read_data,
  input  logic [DW-1:0] alu_in,
  input  logic [4:0]    mux_reg_dst,
  input  logic [DW-1:0] addPC,
  output logic [DW-1:0] wb_data,
  input  logic [4:0]    read_reg1,
  input  logic [4:0]    read_reg2,
  input  logic          use1,
  input  logic          use2,
  output logic [DW-1:0] read_data1,
  output logic [DW-1:0] read_data2,
  input  logic          issue_valid,
  input  logic [4:0]    issue_reg,
  input  logic          kill_valid,
  input  logic [4:0]    kill_reg,
  output logic          stall,
  output logic          sb_error
);

  logic [DW-1:0] regs_r        [NREG];
  logic [CW-1:0] pending_r     [NREG];
  logic [CW-1:0] pending_nxt_s [NREG];
  logic [DW-1:0] wb_data_s;
  logic [DW-1:0] rd1_s, rd2_s;
  logic [CW:0]   res_s;
  logic          err_any_s;
  logic          ret1_s, ret2_s, hazard1_s, hazard2_s;
  logic          sb_error_r;

  // Returns {error, clamped count} for cur + inc - dec_wb - dec_kill.
  function automatic logic [CW:0] next_count(input logic [CW-1:0] cur, input logic inc,
                                             input logic dec_wb, input logic dec_kill);
    logic signed [CW+1:0] sum;
    sum = $signed({2'b00, cur}) + $signed({{(CW+1){1'b0}}, inc})
        - $signed({{(CW+1){1'b0}}, dec_wb}) - $signed({{(CW+1){1'b0}}, dec_kill});
    if (sum < $signed({(CW+2){1'b0}})) begin
      next_count = {1'b1, {CW{1'b0}}};
    end else if (sum > $signed({2'b00, {CW{1'b1}}})) begin
      next_count = {1'b1, {CW{1'b1}}};
    end else begin
      next_count = {1'b0, sum[CW-1:0]};
    end
  endfunction

  // Write-back source select; the reserved encoding falls back to the ALU result.
  always_comb begin
    case (mem_to_reg)
      2'b00:   wb_data_s = alu_in;
      2'b01:   wb_data_s = read_data;
      2'b10:   wb_data_s = addPC;
      default: wb_data_s = alu_in;
    endcase
  end

  // Read ports with bypass of the value retiring this cycle.
  always_comb begin
    ret1_s = reg_write && (mux_reg_dst == read_reg1);
    ret2_s = reg_write && (mux_reg_dst == read_reg2);
    if (read_reg1 == 5'd0) begin
      rd1_s = {DW{1'b0}};
    end else if (ret1_s) begin
      rd1_s = wb_data_s;
    end else begin
      rd1_s = regs_r[read_reg1];
    end
    if (read_reg2 == 5'd0) begin
      rd2_s = {DW{1'b0}};
    end else if (ret2_s) begin
      rd2_s = wb_data_s;
    end else begin
      rd2_s = regs_r[read_reg2];
    end
  end

  // RAW hazard: outstanding producers beyond the one covered by the bypass.
  always_comb begin
    hazard1_s = (read_reg1 != 5'd0) && (pending_r[read_reg1] > CW'(ret1_s));
    hazard2_s = (read_reg2 != 5'd0) && (pending_r[read_reg2] > CW'(ret2_s));
  end

  // Next pending counts; $0 is never tracked.
  always_comb begin
    err_any_s        = 1'b0;
    res_s            = {(CW+1){1'b0}};
    pending_nxt_s[0] = {CW{1'b0}};
    for (int r = 1; r < NREG; r++) begin
      res_s = next_count(pending_r[r],
                         issue_valid && (issue_reg == r[4:0]),
                         reg_write && (mux_reg_dst == r[4:0]),
                         kill_valid && (kill_reg == r[4:0]));
      pending_nxt_s[r] = res_s[CW-1:0];
      err_any_s        = err_any_s | res_s[CW];
    end
  end

  // Register file, scoreboard and sticky error state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i]    <= {DW{1'b0}};
        pending_r[i] <= {CW{1'b0}};
      end
      sb_error_r <= 1'b0;
    end else begin
      if (reg_write && (mux_reg_dst != 5'd0)) begin
        regs_r[mux_reg_dst] <= wb_data_s;
      end
      for (int i = 0; i < NREG; i++) begin
        pending_r[i] <= pending_nxt_s[i];
      end
      sb_error_r <= sb_error_r | err_any_s;
    end
  end

  assign wb_data    = wb_data_s;
  assign read_data1 = rd1_s;
  assign read_data2 = rd2_s;
  assign stall      = (use1 && hazard1_s) || (use2 && hazard2_s);
  assign sb_error   = sb_error_r;

endmodule
